crg_switch_ctrl: RTL and testbench

CRG_SWITCH_CTRL -- requirements
Module: crg_switch_ctrl

---
 rtl/crg_switch_ctrl_pkg.sv | 27 ++
 rtl/crg_switch_ctrl_if.sv | 14 +
 rtl/crg_sw_cnt.sv | 28 ++
 rtl/crg_switch_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_crg_switch_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/crg_switch_ctrl_pkg.sv
// crg_pkg: shared types and defaults for the clock/reset switch controller.
//   crg_sw_state_t  - controller state encoding
//   *_CYC_DEF       - default cycle counts for the top-level parameters
//   crg_cnt_width() - counter width covering the largest cycle count
package crg_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    QUIESCE = 3'd1,
    SWITCH  = 3'd2,
    SETTLE  = 3'd3,
    ERROR   = 3'd4
  } crg_sw_state_t;

  localparam int QUIESCE_CYC_DEF = 16;
  localparam int SETTLE_CYC_DEF  = 64;
  localparam int TIMEOUT_CYC_DEF = 4096;

  function automatic int crg_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/crg_switch_ctrl_if.sv
// crg_switch_ctrl_if: reconfiguration request handshake.
//   req_valid - request valid (master -> slave)
//   req_ready - request accepted when high with req_valid (slave -> master)
//   req_sel   - requested clk1 mux select
//   req_cen   - requested clk2 gate enable
interface crg_switch_ctrl_if;
  logic req_valid;
  logic req_ready;
  logic req_sel;
  logic req_cen;

  modport master (output req_valid, output req_sel, output req_cen, input req_ready);
  modport slave  (input req_valid, input req_sel, input req_cen, output req_ready);
endinterface

// File: rtl/crg_sw_cnt.sv
// crg_sw_cnt: loadable down-counter that saturates at zero.
//   clk_src, rst_n_sys - clock, async active-low reset (loads RST_VAL)
//   load, load_val     - synchronous load (has priority over dec)
//   dec                - decrement by one, holds at zero
//   zero               - counter currently reads zero
module crg_sw_cnt #(
  parameter int            W       = 8,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_src,
  input  logic         rst_n_sys,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_src or negedge rst_n_sys) begin
    if (!rst_n_sys)             cnt <= RST_VAL;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - W'(1);
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/crg_switch_ctrl.sv
// crg_switch_ctrl: sequences clock mux/gate changes for the CRG by holding the
// domain reset across the change and releasing it once the MMCM is locked.
//   clk_src, rst_n_sys - controller clock, async active-low reset
//   req_if (slave)     - request handshake: req_valid/req_ready/req_sel/req_cen
//   mmcm_locked        - MMCM lock, synchronous to clk_src
//   clk1_sel, clk2_cen - registered mux select / gate enable to the CRG
//   dom_rst_n          - active-low domain reset hold
//   done               - one-cycle pulse when a reconfiguration completes
//   err                - sticky lock-timeout flag
// Optional feature: define CRG_SWITCH_CTRL_TIMEOUT_EN to enable the lock
// timeout and the ERROR state; otherwise err is tied low and SETTLE waits
// for lock indefinitely. All cycle parameters must be at least 1.
//
// state   | meaning
// IDLE    | domain running, request accepted
// QUIESCE | domain reset held before the clock change
// SWITCH  | one cycle, new mux/gate values applied on exit
// SETTLE  | minimum hold after a change / lock loss, waits for lock
// ERROR   | lock timeout, reset held, waits for a new request
module crg_switch_ctrl
  import crg_pkg::*;
#(
  parameter int QUIESCE_CYC = QUIESCE_CYC_DEF,
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                clk_src,
  input  logic                rst_n_sys,
  crg_switch_ctrl_if.slave    req_if,
  input  logic                mmcm_locked,
  output logic                clk1_sel,
  output logic                clk2_cen,
  output logic                dom_rst_n,
  output logic                done,
  output logic                err
);

  localparam int            CW     = crg_cnt_width(QUIESCE_CYC, SETTLE_CYC, TIMEOUT_CYC);
  localparam logic [CW-1:0] Q_LD   = CW'(QUIESCE_CYC - 1);
  localparam logic [CW-1:0] S_LD   = CW'(SETTLE_CYC - 1);

  crg_sw_state_t state, state_nxt;
  logic          cap_sel, cap_cen;
  logic          sel_nxt, cen_nxt, dom_nxt, done_nxt;
  logic          cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0] cnt_ld_val;
  logic          hs, hs_change;

  assign hs        = req_if.req_valid && req_if.req_ready;
  assign hs_change = (req_if.req_sel != clk1_sel) || (req_if.req_cen != clk2_cen);

`ifdef CRG_SWITCH_CTRL_TIMEOUT_EN
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT_CYC - 1);
  logic [CW-1:0] tmo_cnt, tmo_nxt;
  logic          err_q, err_nxt;

  assign req_if.req_ready = (state == IDLE) || (state == ERROR);
  assign err              = err_q;
`else
  assign req_if.req_ready = (state == IDLE);
  assign err              = 1'b0;
`endif

  crg_sw_cnt #(.W(CW), .RST_VAL(S_LD)) u_cnt (
    .clk_src   (clk_src),
    .rst_n_sys (rst_n_sys),
    .load      (cnt_load),
    .load_val  (cnt_ld_val),
    .dec       (cnt_dec),
    .zero      (cnt_zero)
  );

  always_comb begin
    state_nxt  = state;
    sel_nxt    = clk1_sel;
    cen_nxt    = clk2_cen;
    dom_nxt    = dom_rst_n;
    done_nxt   = 1'b0;
    cnt_load   = 1'b0;
    cnt_ld_val = S_LD;
    cnt_dec    = 1'b0;
`ifdef CRG_SWITCH_CTRL_TIMEOUT_EN
    tmo_nxt    = tmo_cnt;
    err_nxt    = err_q;
`endif
    case (state)
      IDLE: begin
        if (hs && hs_change) begin
          state_nxt  = QUIESCE;
          dom_nxt    = 1'b0;
          cnt_load   = 1'b1;
          cnt_ld_val = Q_LD;
        end else if (!mmcm_locked) begin
          // lock lost while running: hold the domain and re-run the settle wait
          state_nxt = SETTLE;
          dom_nxt   = 1'b0;
          cnt_load  = 1'b1;
`ifdef CRG_SWITCH_CTRL_TIMEOUT_EN
          tmo_nxt   = '0;
`endif
        end else if (hs) begin
          done_nxt = 1'b1;
        end
      end
      QUIESCE: begin
        if (cnt_zero) state_nxt = SWITCH;
        else          cnt_dec   = 1'b1;
      end
      SWITCH: begin
        sel_nxt   = cap_sel;
        cen_nxt   = cap_cen;
        state_nxt = SETTLE;
        cnt_load  = 1'b1;
`ifdef CRG_SWITCH_CTRL_TIMEOUT_EN
        tmo_nxt   = '0;
`endif
      end
      SETTLE: begin
        if (cnt_zero && mmcm_locked) begin
          state_nxt = IDLE;
          dom_nxt   = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          // the minimum-hold count keeps running while unlocked
          cnt_dec = 1'b1;
`ifdef CRG_SWITCH_CTRL_TIMEOUT_EN
          if (!mmcm_locked) begin
            if (tmo_cnt == T_LAST) begin
              state_nxt = ERROR;
              err_nxt   = 1'b1;
            end else begin
              tmo_nxt = tmo_cnt + CW'(1);
            end
          end
`endif
        end
      end
`ifdef CRG_SWITCH_CTRL_TIMEOUT_EN
      ERROR: begin
        if (hs) begin
          state_nxt  = QUIESCE;
          err_nxt    = 1'b0;
          cnt_load   = 1'b1;
          cnt_ld_val = Q_LD;
        end
      end
`endif
      default: begin
        state_nxt = SETTLE;
        dom_nxt   = 1'b0;
        cnt_load  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_src or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      state     <= SETTLE;
      clk1_sel  <= 1'b0;
      clk2_cen  <= 1'b0;
      dom_rst_n <= 1'b0;
      done      <= 1'b0;
      cap_sel   <= 1'b0;
      cap_cen   <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk1_sel  <= sel_nxt;
      clk2_cen  <= cen_nxt;
      dom_rst_n <= dom_nxt;
      done      <= done_nxt;
      if (hs) begin
        cap_sel <= req_if.req_sel;
        cap_cen <= req_if.req_cen;
      end
    end
  end

`ifdef CRG_SWITCH_CTRL_TIMEOUT_EN
  always_ff @(posedge clk_src or negedge rst_n_sys) begin
    if (!rst_n_sys) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= tmo_nxt;
      err_q   <= err_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_crg_switch_ctrl.sv
// Directed bench for crg_switch_ctrl with QUIESCE_CYC=4, SETTLE_CYC=8,
// TIMEOUT_CYC=32. Cycle T is the cycle whose closing edge samples the
// handshake; outputs are observed 1 time unit after each rising edge.
module tb_crg_switch_ctrl;

  logic clk_src = 1'b0;
  logic rst_n_sys;
  logic mmcm_locked;
  logic clk1_sel, clk2_cen, dom_rst_n, done, err;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   done_seen;

  crg_switch_ctrl_if bus ();

  crg_switch_ctrl #(.QUIESCE_CYC(4), .SETTLE_CYC(8), .TIMEOUT_CYC(32)) dut (
    .clk_src     (clk_src),
    .rst_n_sys   (rst_n_sys),
    .req_if      (bus.slave),
    .mmcm_locked (mmcm_locked),
    .clk1_sel    (clk1_sel),
    .clk2_cen    (clk2_cen),
    .dom_rst_n   (dom_rst_n),
    .done        (done),
    .err         (err)
  );

  always #5 clk_src = ~clk_src;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_src);
      #1;
      if (done) done_seen++;
    end
  endtask

  task automatic req(input logic sel, input logic cen);
    bus.req_valid = 1'b1;
    bus.req_sel   = sel;
    bus.req_cen   = cen;
    ticks(1);
    bus.req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_sys     = 1'b0;
    mmcm_locked   = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_sel   = 1'b0;
    bus.req_cen   = 1'b0;
    done_seen     = 0;
    ticks(3);
    chk("rst_dom", dom_rst_n, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_sel", clk1_sel, 1'b0);
    chk("rst_cen", clk2_cen, 1'b0);
    chk("rst_ready", bus.req_ready, 1'b0);

    // release: done 8 cycles later
    rst_n_sys = 1'b1;
    done_seen = 0;
    ticks(7);
    chk("rel_early_done", done_seen == 0, 1'b1);
    chk("rel_dom_held", dom_rst_n, 1'b0);
    ticks(1);
    chk("rel_done", done, 1'b1);
    chk("rel_dom", dom_rst_n, 1'b1);
    chk("rel_ready", bus.req_ready, 1'b1);
    chk("rel_sel", clk1_sel, 1'b0);
    ticks(1);
    chk("rel_done_pulse", done, 1'b0);

    // clock change sel=1 cen=0; an ignored request mid-QUIESCE
    req(1'b1, 1'b0);                              // now T+1
    chk("sw1_dom_low", dom_rst_n, 1'b0);
    chk("sw1_ready_low", bus.req_ready, 1'b0);
    bus.req_valid = 1'b1; bus.req_sel = 1'b0; bus.req_cen = 1'b1;
    ticks(1);                                     // T+2
    bus.req_valid = 1'b0;
    ticks(3);                                     // T+5 SWITCH
    chk("sw1_sel_pre", clk1_sel, 1'b0);
    ticks(1);                                     // T+6
    chk("sw1_sel", clk1_sel, 1'b1);
    chk("sw1_cen", clk2_cen, 1'b0);
    done_seen = 0;
    ticks(7);                                     // T+13
    chk("sw1_no_early_done", done_seen == 0, 1'b1);
    chk("sw1_dom_held", dom_rst_n, 1'b0);
    ticks(1);                                     // T+14
    chk("sw1_done", done, 1'b1);
    chk("sw1_dom_rel", dom_rst_n, 1'b1);
    ticks(1);
    chk("sw1_done_pulse", done, 1'b0);

    // same-value request: immediate done, dom_rst_n stays high
    req(1'b1, 1'b0);
    chk("same_done", done, 1'b1);
    chk("same_dom", dom_rst_n, 1'b1);
    ticks(1);
    chk("same_done_pulse", done, 1'b0);
    chk("same_dom2", dom_rst_n, 1'b1);

    // change cen only, then lose lock for 20 cycles in SETTLE
    req(1'b1, 1'b1);                              // T+1
    ticks(5);                                     // T+6
    chk("sw2_cen", clk2_cen, 1'b1);
    chk("sw2_sel", clk1_sel, 1'b1);
    mmcm_locked = 1'b0;
    done_seen = 0;
    ticks(20);
    chk("unlk_no_done", done_seen == 0, 1'b1);
    chk("unlk_err", err, 1'b0);
    chk("unlk_dom", dom_rst_n, 1'b0);
    mmcm_locked = 1'b1;
    ticks(1);
    chk("relock_done", done, 1'b1);
    chk("relock_dom", dom_rst_n, 1'b1);

    // lock drop while IDLE
    ticks(1);
    mmcm_locked = 1'b0;
    ticks(1);                                     // k+1
    chk("idle_drop_dom", dom_rst_n, 1'b0);
    chk("idle_drop_ready", bus.req_ready, 1'b0);
    mmcm_locked = 1'b1;
    done_seen = 0;
    ticks(7);                                     // k+8
    chk("idle_drop_no_early", done_seen == 0, 1'b1);
    ticks(1);                                     // k+9
    chk("idle_drop_done", done, 1'b1);
    chk("idle_drop_dom_rel", dom_rst_n, 1'b1);

    // change cen back to 0 and hold lock low in SETTLE
    req(1'b1, 1'b0);                              // T+1
    ticks(5);                                     // T+6
    chk("sw3_cen", clk2_cen, 1'b0);
    mmcm_locked = 1'b0;
    ticks(31);                                    // T+37
    chk("tmo_err_pre", err, 1'b0);
    ticks(1);                                     // T+38
`ifdef CRG_SWITCH_CTRL_TIMEOUT_EN
    chk("tmo_err", err, 1'b1);
    chk("tmo_dom", dom_rst_n, 1'b0);
    chk("tmo_ready", bus.req_ready, 1'b1);
    req(1'b1, 1'b0);                              // T'+1
    chk("tmo_err_clr", err, 1'b0);
    chk("tmo_quiesce_dom", dom_rst_n, 1'b0);
    mmcm_locked = 1'b1;
    done_seen = 0;
    ticks(12);                                    // T'+13
    chk("tmo_no_early", done_seen == 0, 1'b1);
    ticks(1);                                     // T'+14
    chk("tmo_done", done, 1'b1);
    chk("tmo_dom_rel", dom_rst_n, 1'b1);
`else
    chk("notmo_err", err, 1'b0);
    chk("notmo_dom", dom_rst_n, 1'b0);
    chk("notmo_ready", bus.req_ready, 1'b0);
    mmcm_locked = 1'b1;
    ticks(1);
    chk("notmo_done", done, 1'b1);
    chk("notmo_dom_rel", dom_rst_n, 1'b1);
`endif
    ticks(1);

    // reset mid-QUIESCE abandons the request
    req(1'b0, 1'b1);                              // T+1
    ticks(1);                                     // T+2
    chk("q_sel_before", clk1_sel, 1'b1);
    rst_n_sys = 1'b0;
    #1;
    chk("qrst_sel", clk1_sel, 1'b0);
    chk("qrst_cen", clk2_cen, 1'b0);
    chk("qrst_dom", dom_rst_n, 1'b0);
    chk("qrst_done", done, 1'b0);
    chk("qrst_err", err, 1'b0);
    chk("qrst_ready", bus.req_ready, 1'b0);
    done_seen = 0;
    ticks(3);
    rst_n_sys = 1'b1;
    ticks(7);
    chk("qrst_no_done", done_seen == 0, 1'b1);
    ticks(1);
    chk("qrst_rel_done", done, 1'b1);
    chk("qrst_rel_sel", clk1_sel, 1'b0);
    chk("qrst_rel_cen", clk2_cen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
